// File: rtl/vis_sequencer_pkg.sv
// Shared definitions for the correlator run-control sequencer: state encoding
// and the accumulator block-count width helper.
package vis_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ARMED = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_ERROR = 3'd5
  } vis_state_t;

  // A block count must cover one more bit than the headroom above a partial sum.
  function automatic int cnt_width(input int accum, input int sbits);
    return accum - sbits + 1;
  endfunction

endpackage

// File: rtl/vis_sequencer.sv
// Run-control FSM for the correlator datapath: owns the datapath reset, latches
// the block count, aligns start to the first buffered block and counts frames.
module vis_sequencer
  import vis_sequencer_pkg::*;
#(
  parameter int ACCUM  = 32,
  parameter int SBITS  = 7,
  parameter int FBITS  = 16,
  parameter int RSTCYC = 4,
  localparam int CNTW  = cnt_width(ACCUM, SBITS)
) (
  input  logic             clock,
  input  logic             areset_n,
  input  logic             cfg_start_i,
  input  logic             cfg_stop_i,
  input  logic             cfg_clear_i,
  input  logic [CNTW-1:0]  cfg_limit_i,
  input  logic [FBITS-1:0] cfg_frames_i,
  input  logic             buf_valid_i,
  input  logic             buf_first_i,
  input  logic             acc_valid_i,
  input  logic             acc_last_i,
  input  logic             acc_ready_i,
  output logic             vis_reset_o,
  output logic [CNTW-1:0]  count_o,
  output logic             busy_o,
  output logic             start_o,
  output logic             done_o,
  output logic             ovf_o,
  output logic [FBITS-1:0] frames_o
);

  localparam int CLRW = (RSTCYC > 1) ? $clog2(RSTCYC) : 1;

  vis_state_t       r_state, w_state_next;
  logic [CLRW-1:0]  r_clr_cnt, w_clr_next;
  logic [CNTW-1:0]  r_limit, w_limit_next;
  logic [FBITS-1:0] r_flim, w_flim_next;
  logic [FBITS-1:0] r_frames, w_frames_next;
  logic             r_start, w_start_next;
  logic             r_done, w_done_next;
  logic             r_ovf, w_ovf_next;
  logic             r_vis_reset, w_vis_reset_next;
  logic             r_busy, w_busy_next;

  logic             w_ovf_evt;
  logic             w_last;
  logic [FBITS-1:0] w_frames_inc;

  assign w_ovf_evt    = acc_valid_i & ~acc_ready_i;
  assign w_last       = acc_valid_i & acc_ready_i & acc_last_i;
  assign w_frames_inc = (r_frames == '1) ? r_frames : r_frames + 1'b1;

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      r_state     <= ST_IDLE;
      r_clr_cnt   <= '0;
      r_limit     <= '0;
      r_flim      <= '0;
      r_frames    <= '0;
      r_start     <= 1'b0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
      r_vis_reset <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_clr_cnt   <= w_clr_next;
      r_limit     <= w_limit_next;
      r_flim      <= w_flim_next;
      r_frames    <= w_frames_next;
      r_start     <= w_start_next;
      r_done      <= w_done_next;
      r_ovf       <= w_ovf_next;
      r_vis_reset <= w_vis_reset_next;
      r_busy      <= w_busy_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_clr_next    = r_clr_cnt;
    w_limit_next  = r_limit;
    w_flim_next   = r_flim;
    w_frames_next = r_frames;
    w_start_next  = 1'b0;
    w_done_next   = 1'b0;
    w_ovf_next    = r_ovf;
    case (r_state)
      ST_IDLE: begin
        if (cfg_start_i) begin
          w_limit_next  = (cfg_limit_i == '0) ? CNTW'(1) : cfg_limit_i;
          w_flim_next   = cfg_frames_i;
          w_frames_next = '0;
          w_clr_next    = CLRW'(RSTCYC - 1);
          w_state_next  = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (r_clr_cnt == '0) w_state_next = ST_ARMED;
        else                 w_clr_next   = r_clr_cnt - 1'b1;
      end
      // Overflow outranks every other event in the acquisition states.
      ST_ARMED: begin
        if (w_ovf_evt) begin
          w_ovf_next   = 1'b1;
          w_state_next = ST_ERROR;
        end else if (buf_valid_i && buf_first_i) begin
          w_start_next = 1'b1;
          w_state_next = ST_RUN;
        end else if (cfg_stop_i) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_ovf_evt) begin
          w_ovf_next   = 1'b1;
          w_state_next = ST_ERROR;
        end else if (w_last) begin
          w_frames_next = w_frames_inc;
          // A stop arriving with a frame's last word needs no drain phase.
          if ((r_flim != '0 && w_frames_inc == r_flim) || cfg_stop_i) begin
            w_done_next  = 1'b1;
            w_state_next = ST_IDLE;
          end
        end else if (cfg_stop_i) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_ovf_evt) begin
          w_ovf_next   = 1'b1;
          w_state_next = ST_ERROR;
        end else if (w_last) begin
          w_frames_next = w_frames_inc;
          w_done_next   = 1'b1;
          w_state_next  = ST_IDLE;
        end
      end
      ST_ERROR: begin
        if (cfg_clear_i) begin
          w_ovf_next   = 1'b0;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    w_vis_reset_next = (w_state_next == ST_IDLE) || (w_state_next == ST_CLEAR) ||
                       (w_state_next == ST_ERROR);
    w_busy_next      = (w_state_next != ST_IDLE) && (w_state_next != ST_ERROR);
  end

  assign vis_reset_o = r_vis_reset;
  assign count_o     = r_limit;
  assign busy_o      = r_busy;
  assign start_o     = r_start;
  assign done_o      = r_done;
  assign ovf_o       = r_ovf;
  assign frames_o    = r_frames;

endmodule

// File: tb/tb_vis_sequencer.sv
// Self-checking bench for vis_sequencer: start/done pulses are matched against a
// scoreboard queue, level outputs are compared directly after each step.
module tb_vis_sequencer;

  localparam int CNTW   = 26;
  localparam int FBITS  = 16;
  localparam int RSTCYC = 4;

  typedef struct packed {
    logic             is_done;
    logic [FBITS-1:0] frames;
  } sb_item_t;

  logic             clock = 1'b0;
  logic             areset_n = 1'b0;
  logic             cfg_start_i = 1'b0, cfg_stop_i = 1'b0, cfg_clear_i = 1'b0;
  logic [CNTW-1:0]  cfg_limit_i = '0;
  logic [FBITS-1:0] cfg_frames_i = '0;
  logic             buf_valid_i = 1'b0, buf_first_i = 1'b0;
  logic             acc_valid_i = 1'b0, acc_last_i = 1'b0, acc_ready_i = 1'b1;
  logic             vis_reset_o, busy_o, start_o, done_o, ovf_o;
  logic [CNTW-1:0]  count_o;
  logic [FBITS-1:0] frames_o;

  int       n_checks = 0;
  int       n_fail   = 0;
  sb_item_t sb_q[$];

  vis_sequencer #(.ACCUM(32), .SBITS(7), .FBITS(FBITS), .RSTCYC(RSTCYC)) dut (
    .clock(clock), .areset_n(areset_n),
    .cfg_start_i(cfg_start_i), .cfg_stop_i(cfg_stop_i), .cfg_clear_i(cfg_clear_i),
    .cfg_limit_i(cfg_limit_i), .cfg_frames_i(cfg_frames_i),
    .buf_valid_i(buf_valid_i), .buf_first_i(buf_first_i),
    .acc_valid_i(acc_valid_i), .acc_last_i(acc_last_i), .acc_ready_i(acc_ready_i),
    .vis_reset_o(vis_reset_o), .count_o(count_o), .busy_o(busy_o),
    .start_o(start_o), .done_o(done_o), .ovf_o(ovf_o), .frames_o(frames_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s value=%0d t=%0t", tag, got, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Pulse outputs are checked on the falling edge against the scoreboard.
  always @(negedge clock) begin
    sb_item_t e;
    if (areset_n && (start_o || done_o)) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_pulse", 64'({done_o, start_o}), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_pulse_kind", 64'({done_o, start_o}), e.is_done ? 64'd2 : 64'd1);
        if (e.is_done) check("sb_done_frames", 64'(frames_o), 64'(e.frames));
      end
    end
  end

  task automatic do_start(input logic [CNTW-1:0] lim, input logic [FBITS-1:0] frm);
    cfg_limit_i = lim; cfg_frames_i = frm; cfg_start_i = 1'b1;
    cyc(1);
    cfg_start_i = 1'b0;
  endtask

  // Counts cycles spent in CLEAR (busy with datapath reset held), bounded.
  task automatic run_clear(input string tag);
    int n;
    n = 0;
    while (vis_reset_o && busy_o && n < 50) begin
      n++;
      cyc(1);
    end
    check(tag, 64'(n), 64'(RSTCYC));
    check({tag, "_armed_rst"}, 64'(vis_reset_o), 64'd0);
  endtask

  task automatic first_block();
    sb_q.push_back('{is_done: 1'b0, frames: '0});
    buf_valid_i = 1'b1; buf_first_i = 1'b1;
    cyc(1);
    buf_valid_i = 1'b0; buf_first_i = 1'b0;
  endtask

  task automatic frame_word(input logic last, input logic expect_done, input int exp_frames);
    if (expect_done) sb_q.push_back('{is_done: 1'b1, frames: FBITS'(exp_frames)});
    acc_valid_i = 1'b1; acc_ready_i = 1'b1; acc_last_i = last;
    cyc(1);
    acc_valid_i = 1'b0; acc_last_i = 1'b0;
  endtask

  initial begin
    fork
      begin
        #500000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
      end
    join_none

    // Reset values
    cyc(2);
    check("rst_vis_reset", 64'(vis_reset_o), 64'd1);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_ovf", 64'(ovf_o), 64'd0);
    check("rst_frames", 64'(frames_o), 64'd0);
    check("rst_pulses", 64'({start_o, done_o}), 64'd0);
    areset_n = 1'b1;
    cyc(2);

    // 1: limit=3 frames=2, first block at cycle 20
    do_start(26'd3, 16'd2);
    check("t1_count", 64'(count_o), 64'd3);
    check("t1_busy", 64'(busy_o), 64'd1);
    run_clear("t1_clear_len");
    buf_valid_i = 1'b1;
    cyc(10);
    buf_valid_i = 1'b0;
    check("t1_still_armed", 64'({busy_o, vis_reset_o}), 64'd2);
    first_block();
    frame_word(1'b0, 1'b0, 0);
    frame_word(1'b1, 1'b0, 0);
    check("t1_frames1", 64'(frames_o), 64'd1);
    frame_word(1'b0, 1'b0, 0);
    frame_word(1'b1, 1'b1, 2);
    check("t1_frames2", 64'(frames_o), 64'd2);
    check("t1_idle_busy", 64'(busy_o), 64'd0);
    check("t1_idle_rst", 64'(vis_reset_o), 64'd1);
    cyc(3);

    // 2: continuous run, stop mid-frame after frame 3, drain frame 4
    do_start(26'd5, 16'd0);
    run_clear("t2_clear_len");
    first_block();
    for (int i = 0; i < 3; i++) frame_word(1'b1, 1'b0, 0);
    check("t2_frames3", 64'(frames_o), 64'd3);
    acc_valid_i = 1'b1; cfg_stop_i = 1'b1;
    cyc(1);
    acc_valid_i = 1'b0; cfg_stop_i = 1'b0;
    cyc(2);
    check("t2_drain_busy", 64'(busy_o), 64'd1);
    check("t2_drain_frames", 64'(frames_o), 64'd3);
    frame_word(1'b0, 1'b0, 0);
    frame_word(1'b1, 1'b1, 4);
    check("t2_frames4", 64'(frames_o), 64'd4);
    check("t2_idle", 64'(busy_o), 64'd0);
    cyc(2);

    // 3: overflow in RUN -> ERROR; start ignored; clear -> IDLE
    do_start(26'd6, 16'd0);
    run_clear("t3_clear_len");
    first_block();
    frame_word(1'b1, 1'b0, 0);
    acc_valid_i = 1'b1; acc_ready_i = 1'b0;
    cyc(1);
    acc_valid_i = 1'b0; acc_ready_i = 1'b1;
    check("t3_ovf", 64'(ovf_o), 64'd1);
    check("t3_err_rst", 64'(vis_reset_o), 64'd1);
    check("t3_err_busy", 64'(busy_o), 64'd0);
    do_start(26'd11, 16'd1);
    cyc(2);
    check("t3_start_ign_ovf", 64'(ovf_o), 64'd1);
    check("t3_start_ign_cnt", 64'(count_o), 64'd6);
    check("t3_start_ign_busy", 64'(busy_o), 64'd0);
    cfg_clear_i = 1'b1;
    cyc(1);
    cfg_clear_i = 1'b0;
    check("t3_clear_ovf", 64'(ovf_o), 64'd0);
    check("t3_clear_rst", 64'(vis_reset_o), 64'd1);
    cfg_stop_i = 1'b1;
    cyc(1);
    cfg_stop_i = 1'b0;
    check("t3_idle_stop_ign", 64'({busy_o, ovf_o}), 64'd0);

    // 4: overflow beats last+stop; stop with final last -> done, no drain
    do_start(26'd2, 16'd3);
    run_clear("t4_clear_len");
    first_block();
    frame_word(1'b1, 1'b0, 0);
    frame_word(1'b1, 1'b0, 0);
    acc_valid_i = 1'b1; acc_ready_i = 1'b0; acc_last_i = 1'b1; cfg_stop_i = 1'b1;
    cyc(1);
    acc_valid_i = 1'b0; acc_ready_i = 1'b1; acc_last_i = 1'b0; cfg_stop_i = 1'b0;
    check("t4_ovf_wins", 64'(ovf_o), 64'd1);
    check("t4_ovf_frames", 64'(frames_o), 64'd2);
    cfg_clear_i = 1'b1;
    cyc(1);
    cfg_clear_i = 1'b0;
    do_start(26'd2, 16'd3);
    run_clear("t4b_clear_len");
    first_block();
    frame_word(1'b1, 1'b0, 0);
    frame_word(1'b1, 1'b0, 0);
    cfg_stop_i = 1'b1;
    frame_word(1'b1, 1'b1, 3);
    cfg_stop_i = 1'b0;
    check("t4_stop_last_idle", 64'(busy_o), 64'd0);
    check("t4_stop_last_frames", 64'(frames_o), 64'd3);
    cyc(2);

    // 5: limit 0 saturates to 1; stop in ARMED; limit change mid-run
    do_start(26'd0, 16'd0);
    check("t5_limit0", 64'(count_o), 64'd1);
    run_clear("t5_clear_len");
    cfg_limit_i = 26'd77; cfg_stop_i = 1'b1;
    cyc(1);
    cfg_stop_i = 1'b0;
    check("t5_armed_stop", 64'(busy_o), 64'd0);
    check("t5_idle_count", 64'(count_o), 64'd1);
    cyc(2);
    do_start(26'd9, 16'd0);
    run_clear("t5b_clear_len");
    first_block();
    cfg_limit_i = 26'd4;
    cyc(3);
    check("t5_midrun_count", 64'(count_o), 64'd9);

    // 6: asynchronous reset while running
    #2 areset_n = 1'b0;
    #1;
    check("t6_async_rst", 64'({vis_reset_o, busy_o, ovf_o, start_o, done_o}), 64'b10000);
    check("t6_async_count", 64'(count_o), 64'd0);
    check("t6_async_frames", 64'(frames_o), 64'd0);
    cyc(1);
    areset_n = 1'b1;
    cyc(1);
    do_start(26'd4, 16'd1);
    run_clear("t6_clear_len");
    first_block();
    frame_word(1'b1, 1'b1, 1);
    check("t6_done_idle", 64'(busy_o), 64'd0);
    cyc(3);

    check("sb_queue_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
